// File: rtl/ysyx_24100012_mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one data-memory port between IFU (fetch) and LSU.
// Latency: accept at t, mem request t+1, response to owner t+3, next grant t+4 (zero-wait).
// Backpressure: one transaction in flight; requests wait in IDLE, RESP holds until owner ready.
module ysyx_24100012_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0] ifu_req_addr,
    output logic                  ifu_resp_valid,
    input  logic                  ifu_resp_ready,
    output logic [DATA_WIDTH-1:0] ifu_resp_rdata,
    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic                  lsu_req_wen,
    input  logic [1:0]            lsu_req_size,
    input  logic [ADDR_WIDTH-1:0] lsu_req_addr,
    input  logic [DATA_WIDTH-1:0] lsu_req_wdata,
    output logic                  lsu_resp_valid,
    input  logic                  lsu_resp_ready,
    output logic [DATA_WIDTH-1:0] lsu_resp_rdata,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_wen,
    output logic [DATA_WIDTH-1:0] mem_req_len,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t                state, state_nxt;
    logic                  last_lsu;
    logic                  owner_lsu;
    logic                  wen_q;
    logic [DATA_WIDTH-1:0] len_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  grant_ifu, grant_lsu;
    logic [DATA_WIDTH-1:0] lsu_len;

    // Grants are masked while reset is held so nothing is accepted and then dropped.
    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (rst && state == IDLE) begin
            if (ifu_req_valid && (!lsu_req_valid || last_lsu))
                grant_ifu = 1'b1;
            else if (lsu_req_valid)
                grant_lsu = 1'b1;
        end
    end

    always_comb begin
        case (lsu_req_size)
            2'b00:   lsu_len = DATA_WIDTH'(1);
            2'b01:   lsu_len = DATA_WIDTH'(2);
            default: lsu_len = DATA_WIDTH'(4);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (grant_ifu || grant_lsu) state_nxt = REQ;
            REQ:  if (mem_req_ready)          state_nxt = WAIT;
            WAIT: if (mem_resp_valid)         state_nxt = RESP;
            RESP: if (owner_lsu ? lsu_resp_ready : ifu_resp_ready) state_nxt = IDLE;
            default:                          state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_lsu  <= 1'b1;
            owner_lsu <= 1'b0;
            wen_q     <= 1'b0;
            len_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
        end else begin
            if (grant_ifu) begin
                last_lsu  <= 1'b0;
                owner_lsu <= 1'b0;
                wen_q     <= 1'b0;
                len_q     <= DATA_WIDTH'(4);
                addr_q    <= ifu_req_addr;
                wdata_q   <= '0;
            end else if (grant_lsu) begin
                last_lsu  <= 1'b1;
                owner_lsu <= 1'b1;
                wen_q     <= lsu_req_wen;
                len_q     <= lsu_len;
                addr_q    <= lsu_req_addr;
                wdata_q   <= lsu_req_wdata;
            end
            // Store acks carry zero data back to the LSU.
            if (state == WAIT && mem_resp_valid)
                rdata_q <= wen_q ? '0 : mem_resp_rdata;
        end
    end

    always_comb begin
        ifu_req_ready  = grant_ifu;
        lsu_req_ready  = grant_lsu;
        mem_req_valid  = (state == REQ);
        mem_req_wen    = wen_q;
        mem_req_len    = len_q;
        mem_req_addr   = addr_q;
        mem_req_wdata  = wdata_q;
        ifu_resp_valid = (state == RESP) && !owner_lsu;
        lsu_resp_valid = (state == RESP) && owner_lsu;
        ifu_resp_rdata = rdata_q;
        lsu_resp_rdata = rdata_q;
    end

endmodule

// File: tb/tb_ysyx_24100012_mem_arbiter.sv
// Bench for the memory arbiter: directed reset/latency/stall cases plus randomized traffic
// checked against a transaction-level round-robin model; the bench acts as the memory.
module tb_ysyx_24100012_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
    logic [31:0] ifu_req_addr, ifu_resp_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_resp_valid, lsu_resp_ready;
    logic [1:0]  lsu_req_size;
    logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_resp_rdata;
    logic        mem_req_valid, mem_req_ready, mem_req_wen, mem_resp_valid;
    logic [31:0] mem_req_len, mem_req_addr, mem_req_wdata, mem_resp_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: outstanding requests per requester and the last winner.
    bit ifu_pend, lsu_pend, last_lsu;

    always #5 clk = ~clk;

    ysyx_24100012_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_resp_rdata(ifu_resp_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_wen(lsu_req_wen),
        .lsu_req_size(lsu_req_size), .lsu_req_addr(lsu_req_addr), .lsu_req_wdata(lsu_req_wdata),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_resp_rdata(lsu_resp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wen(mem_req_wen),
        .mem_req_len(mem_req_len), .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
    );

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] size_to_len(input logic [1:0] s);
        return (s == 2'b00) ? 32'd1 : (s == 2'b01) ? 32'd2 : 32'd4;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk_eq({tag, ":ifu_req_ready"}, ifu_req_ready, 0);
        chk_eq({tag, ":lsu_req_ready"}, lsu_req_ready, 0);
        chk_eq({tag, ":ifu_resp_valid"}, ifu_resp_valid, 0);
        chk_eq({tag, ":lsu_resp_valid"}, lsu_resp_valid, 0);
        chk_eq({tag, ":mem_req_valid"}, mem_req_valid, 0);
        chk_eq({tag, ":mem_req_wen"}, mem_req_wen, 0);
        chk_eq({tag, ":mem_req_len"}, mem_req_len, 0);
        chk_eq({tag, ":mem_req_addr"}, mem_req_addr, 0);
        chk_eq({tag, ":mem_req_wdata"}, mem_req_wdata, 0);
        chk_eq({tag, ":ifu_resp_rdata"}, ifu_resp_rdata, 0);
        chk_eq({tag, ":lsu_resp_rdata"}, lsu_resp_rdata, 0);
    endtask

    task automatic issue_ifu(input logic [31:0] addr);
        ifu_req_valid = 1'b1;
        ifu_req_addr  = addr;
        ifu_pend      = 1'b1;
    endtask

    task automatic issue_lsu(input logic wen, input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] wdata);
        lsu_req_valid = 1'b1;
        lsu_req_wen   = wen;
        lsu_req_size  = size;
        lsu_req_addr  = addr;
        lsu_req_wdata = wdata;
        lsu_pend      = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One full transaction, entered at a negedge in IDLE with requests already driven.
    task automatic do_txn(input int stall, input int rdelay, input int bp, input logic [31:0] mrdata);
        bit          own_lsu;
        logic        e_wen;
        logic [31:0] e_len, e_addr, e_wdata, e_rdata;
        own_lsu = (ifu_pend && lsu_pend) ? !last_lsu : lsu_pend;
        if (own_lsu) begin
            e_wen = lsu_req_wen; e_len = size_to_len(lsu_req_size);
            e_addr = lsu_req_addr; e_wdata = lsu_req_wdata;
        end else begin
            e_wen = 1'b0; e_len = 32'd4; e_addr = ifu_req_addr; e_wdata = 32'd0;
        end
        e_rdata = e_wen ? 32'd0 : mrdata;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        ifu_resp_ready = 1'b0; lsu_resp_ready = 1'b0;
        #1;
        chk_eq("grant_ifu", ifu_req_ready, !own_lsu);
        chk_eq("grant_lsu", lsu_req_ready, own_lsu);
        chk_eq("idle_mem_valid", mem_req_valid, 0);
        next_cycle();
        last_lsu = own_lsu;
        // Winner drops its request; scrambled payload must not reach memory.
        if (own_lsu) begin
            lsu_pend = 0; lsu_req_valid = 0; lsu_req_addr = $urandom; lsu_req_wdata = $urandom;
            lsu_req_size = 2'($urandom); lsu_req_wen = 1'($urandom);
        end else begin
            ifu_pend = 0; ifu_req_valid = 0; ifu_req_addr = $urandom;
        end
        for (int i = 0; i <= stall; i++) begin
            mem_req_ready  = (i == stall);
            mem_resp_valid = (i < stall) ? 1'($urandom) : 1'b0;
            mem_resp_rdata = $urandom;
            #1;
            chk_eq("req_valid", mem_req_valid, 1);
            chk_eq("req_wen", mem_req_wen, e_wen);
            chk_eq("req_len", mem_req_len, e_len);
            chk_eq("req_addr", mem_req_addr, e_addr);
            chk_eq("req_wdata", mem_req_wdata, e_wdata);
            chk_eq("busy_no_grant", {ifu_req_ready, lsu_req_ready}, 0);
            chk_eq("req_no_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
            next_cycle();
        end
        mem_req_ready = 1'b0;
        for (int i = 0; i <= rdelay; i++) begin
            mem_resp_valid = (i == rdelay);
            mem_resp_rdata = (i == rdelay) ? mrdata : $urandom;
            #1;
            chk_eq("wait_req_valid", mem_req_valid, 0);
            chk_eq("wait_no_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
            next_cycle();
        end
        mem_resp_valid = 1'b0;
        mem_resp_rdata = $urandom;
        for (int i = 0; i <= bp; i++) begin
            if (own_lsu) begin
                lsu_resp_ready = (i == bp); ifu_resp_ready = 1'($urandom);
            end else begin
                ifu_resp_ready = (i == bp); lsu_resp_ready = 1'($urandom);
            end
            #1;
            chk_eq("resp_valid_ifu", ifu_resp_valid, !own_lsu);
            chk_eq("resp_valid_lsu", lsu_resp_valid, own_lsu);
            chk_eq("resp_rdata", own_lsu ? lsu_resp_rdata : ifu_resp_rdata, e_rdata);
            chk_eq("resp_mem_valid", mem_req_valid, 0);
            next_cycle();
        end
        ifu_resp_ready = 1'b0;
        lsu_resp_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not end, expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        ifu_req_valid = 0; ifu_req_addr = 0; ifu_resp_ready = 0;
        lsu_req_valid = 0; lsu_req_wen = 0; lsu_req_size = 0; lsu_req_addr = 0; lsu_req_wdata = 0;
        lsu_resp_ready = 0; mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = 0;
        ifu_pend = 0; lsu_pend = 0; last_lsu = 1;

        issue_ifu(32'h8000_0000);
        issue_lsu(1'b1, 2'b00, 32'h8000_1003, 32'h0000_00AB);
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            chk_all_zero("reset");
        end
        rst = 1'b1;

        // IFU wins the first tie, then strict alternation while both stay valid.
        do_txn(0, 0, 0, 32'h0000_0413);
        issue_ifu(32'h8000_0004);
        do_txn(0, 0, 0, 32'hDEAD_BEEF);
        issue_lsu(1'b0, 2'b01, 32'h8000_2002, 32'h1234_5678);
        do_txn(0, 1, 0, 32'h1111_2222);
        issue_ifu(32'h8000_0008);
        do_txn(0, 0, 0, 32'h3333_4444);
        do_txn(0, 0, 0, 32'h5555_6666);
        issue_lsu(1'b1, 2'b11, 32'h8000_3000, 32'hCAFE_F00D);
        do_txn(3, 0, 2, 32'h7777_8888);

        for (int n = 0; n < 60; n++) begin
            if (!ifu_pend && $urandom_range(1)) issue_ifu($urandom);
            if (!lsu_pend && $urandom_range(1))
                issue_lsu(1'($urandom), 2'($urandom), $urandom, $urandom);
            if (!ifu_pend && !lsu_pend) issue_ifu($urandom);
            do_txn($urandom_range(2), $urandom_range(2), $urandom_range(2), $urandom);
        end

        // Reset while waiting for memory; the late response must be discarded.
        issue_ifu(32'h8000_0100);
        #1;
        chk_eq("rw_grant", {ifu_req_ready, lsu_req_ready}, 2'b10);
        next_cycle();
        ifu_req_valid = 0; ifu_pend = 0;
        mem_req_ready = 1'b1;
        #1;
        chk_eq("rw_req_valid", mem_req_valid, 1);
        next_cycle();
        mem_req_ready = 1'b0;
        rst = 1'b0;
        next_cycle();
        chk_all_zero("rst_in_wait");
        rst = 1'b1;
        last_lsu = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'hBAD0_BAD0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_eq("late_resp_ignored", {ifu_resp_valid, lsu_resp_valid, mem_req_valid}, 0);
            next_cycle();
        end
        mem_resp_valid = 1'b0;
        issue_ifu(32'h8000_0200);
        issue_lsu(1'b0, 2'b10, 32'h8000_0300, 32'h0);
        do_txn(0, 0, 0, 32'hABCD_0001);
        do_txn(1, 1, 1, 32'hABCD_0002);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
